// File: rtl/cordic_stream_ctrl.sv
// Valid/ready stream wrapper around cordic_top: operand FIFO in front,
// single-job issue/track FSM, and a held result register behind the core.
module cordic_stream_ctrl #(
    parameter int B     = 14,
    parameter int N     = 7,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [2*B-1:0]               s_data,
    output logic                         core_en,
    output logic [2*B-1:0]               core_data_w,
    input  logic                         core_busy,
    input  logic [2*B-1:0]               core_data_r,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [2*B-1:0]               m_data,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int DW = 2 * B;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    if (N < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("cordic_stream_ctrl: N must be >= 1, DEPTH a power of two >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RUN,
        S_HOLD
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;

    logic            r_core_en;
    logic [DW-1:0]   r_core_dw;
    logic            r_m_valid;
    logic [DW-1:0]   r_m_data;

    logic            w_s_ready;
    logic            w_push;
    logic            w_pop;
    logic            w_en_nxt;
    logic [DW-1:0]   w_dw_nxt;
    logic            w_mv_nxt;
    logic [DW-1:0]   w_md_nxt;

    // Full is judged on the registered level, so a same-cycle pop never frees a slot
    assign w_s_ready = (r_level != LW'(DEPTH));
    assign w_push    = s_valid && w_s_ready;

    assign s_ready     = w_s_ready;
    assign level       = r_level;
    assign core_en     = r_core_en;
    assign core_data_w = r_core_dw;
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_core_en <= 1'b0;
            r_core_dw <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_core_en <= w_en_nxt;
            r_core_dw <= w_dw_nxt;
            r_m_valid <= w_mv_nxt;
            r_m_data  <= w_md_nxt;
        end
    end

    // Outputs are computed one state early so that they leave the block registered
    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = 1'b0;
        w_dw_nxt    = r_core_dw;
        w_mv_nxt    = r_m_valid;
        w_md_nxt    = r_m_data;
        w_pop       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_level != '0 && !core_busy) begin
                    w_state_nxt = S_START;
                    w_en_nxt    = 1'b1;
                    w_dw_nxt    = r_mem[r_rd_ptr];
                end
            end
            S_START: begin
                w_pop       = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (core_busy) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!core_busy) begin
                    w_md_nxt    = core_data_r;
                    w_mv_nxt    = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (m_ready) begin
                    w_mv_nxt    = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
